// File: rtl/capture_reader.sv
// Streams a finished capture out of the circular sample RAM, oldest sample first.
// Define CAPTURE_READER_HEADER_EN to prefix each readout with 8'hA5 and the trigger offset.
module capture_reader #(
  parameter int SAMPLE_DEPTH = 8,
  parameter int PRETRIG      = 128
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SAMPLE_DEPTH-1:0] offset,
  output logic                    busy,
  output logic                    done,
  output logic [SAMPLE_DEPTH-1:0] mem_addr,
  output logic                    mem_re,
  input  logic [7:0]              mem_data,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int D = SAMPLE_DEPTH;
  localparam logic [D-1:0] PRE = D'(PRETRIG);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef CAPTURE_READER_HEADER_EN
    S_HDR0,
    S_HDR1,
`endif
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t       state;
  logic [D-1:0] base;
  logic [D:0]   cnt;
  logic [D:0]   cnt_nxt;

`ifdef CAPTURE_READER_HEADER_EN
  logic [D-1:0] off_q;
`endif

  assign cnt_nxt = cnt + (D+1)'(1);

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      base      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef CAPTURE_READER_HEADER_EN
      off_q     <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            base <= offset - PRE;
            cnt  <= '0;
            busy <= 1'b1;
`ifdef CAPTURE_READER_HEADER_EN
            off_q     <= offset;
            out_data  <= 8'hA5;
            out_valid <= 1'b1;
            state     <= S_HDR0;
`else
            mem_re   <= 1'b1;
            mem_addr <= offset - PRE;
            state    <= S_FETCH;
`endif
          end
        end
`ifdef CAPTURE_READER_HEADER_EN
        S_HDR0: begin
          if (out_ready) begin
            out_data <= 8'(off_q);
            state    <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            mem_re    <= 1'b1;
            mem_addr  <= base;
            state     <= S_FETCH;
          end
        end
`endif
        S_FETCH: begin
          mem_re <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          out_data  <= mem_data;
          out_valid <= 1'b1;
          state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt       <= cnt_nxt;
            // carry out of the low bits means every sample has gone
            if (cnt_nxt[D]) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              mem_re   <= 1'b1;
              mem_addr <= base + cnt_nxt[D-1:0];
              state    <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_reader.sv
// Directed bench for capture_reader: unwrap order, timing, backpressure,
// mid-readout reset and held start; header beats when CAPTURE_READER_HEADER_EN.
module tb_capture_reader;

`ifdef CAPTURE_READER_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic       clk_50mhz = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] offset;
  logic       busy;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_re;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [256];
  logic [7:0] beats [$];
  logic [7:0] addrs [$];

  always #10 clk_50mhz = ~clk_50mhz;

  capture_reader #(.SAMPLE_DEPTH(8), .PRETRIG(128)) dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .start     (start),
    .offset    (offset),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always @(posedge clk_50mhz) begin
    if (mem_re) mem_data <= ram[mem_addr];
    if (out_valid && out_ready) beats.push_back(out_data);
    if (mem_re) addrs.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [7:0] off);
    beats.delete();
    addrs.delete();
    offset = off;
    start = 1'b1;
    @(negedge clk_50mhz);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk_50mhz);
      k++;
    end
  endtask

  function automatic int seq_errs(input logic [7:0] off);
    int e;
    logic [7:0] b;
    logic [7:0] a;
    e = 0;
    b = off - 8'd128;
    if (beats.size() != 256 + HDR) e++;
    if (addrs.size() != 256) e++;
`ifdef CAPTURE_READER_HEADER_EN
    if (beats[0] !== 8'hA5) e++;
    if (beats[1] !== off) e++;
`endif
    for (int i = 0; i < 256; i++) begin
      a = b + 8'(i);
      if (addrs[i] !== a) e++;
      if (beats[HDR+i] !== a) e++;
    end
    return e;
  endfunction

  initial begin
    int k;
    int bad;
    int n0;
    logic [7:0] held;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i);
    reset = 1'b1;
    start = 1'b0;
    offset = 8'h00;
    out_ready = 1'b1;
    @(negedge clk_50mhz);
    @(negedge clk_50mhz);
    chk("reset_state", {busy, done, mem_re, out_valid, mem_addr, out_data}, 0);
    reset = 1'b0;
    @(negedge clk_50mhz);

    // basic readout, offset 0x90 -> base 0x10
    kick(8'h90);
    start = 1'b0;
`ifdef CAPTURE_READER_HEADER_EN
    chk("first_hdr", {busy, out_valid, out_data, mem_re}, {1'b1, 1'b1, 8'hA5, 1'b0});
`else
    chk("first_fetch", {busy, mem_re, mem_addr}, {1'b1, 1'b1, 8'h10});
`endif
    @(negedge clk_50mhz);
    @(negedge clk_50mhz);
`ifdef CAPTURE_READER_HEADER_EN
    chk("hdr_then_fetch", {mem_re, mem_addr}, {1'b1, 8'h10});
`else
    chk("first_beat", {out_valid, out_data}, {1'b1, 8'h10});
`endif
    wait_done(k);
    chk("cycles_0x90", k + 2, 768 + HDR);
    chk("seq_0x90", seq_errs(8'h90), 0);
    chk("done_state", {busy, done}, 2'b01);
    @(negedge clk_50mhz);
    chk("done_clear", {busy, done}, 2'b00);

    // wrap case, offset 0x20 -> base 0xA0
    kick(8'h20);
    start = 1'b0;
    wait_done(k);
    chk("wrap_first", addrs[0], 8'hA0);
    chk("wrap_96", {addrs[96], beats[HDR+96]}, 16'h0000);
    chk("wrap_last", addrs[255], 8'h9F);
    chk("seq_0x20", seq_errs(8'h20), 0);
    @(negedge clk_50mhz);

    // offset 0x37 -> base 0xB7, also the header example
    kick(8'h37);
    start = 1'b0;
    wait_done(k);
    chk("cycles_0x37", k, 768 + HDR);
    chk("seq_0x37", seq_errs(8'h37), 0);
    @(negedge clk_50mhz);

    // backpressure on beat 5
    kick(8'h90);
    start = 1'b0;
    k = 0;
    while (!(beats.size() == HDR + 5 && out_valid) && k < 100) begin
      @(negedge clk_50mhz);
      k++;
    end
    out_ready = 1'b0;
    held = out_data;
    chk("bp_beat5", held, 8'h15);
    bad = 0;
    n0 = addrs.size();
    repeat (10) begin
      @(negedge clk_50mhz);
      if (!out_valid || out_data !== held || mem_re) bad++;
    end
    chk("bp_hold", bad, 0);
    chk("bp_no_read", addrs.size() - n0, 0);
    out_ready = 1'b1;
    wait_done(k);
    chk("seq_bp", seq_errs(8'h90), 0);
    @(negedge clk_50mhz);

    // reset after 50 beats
    kick(8'h90);
    start = 1'b0;
    k = 0;
    while (beats.size() < HDR + 50 && k < 1000) begin
      @(negedge clk_50mhz);
      k++;
    end
    reset = 1'b1;
    #1;
    chk("rst_mid", {busy, done, mem_re, out_valid, mem_addr, out_data}, 0);
    @(negedge clk_50mhz);
    reset = 1'b0;
    @(negedge clk_50mhz);
    chk("rst_idle", {busy, done, mem_re, out_valid}, 0);
    kick(8'h30);
    start = 1'b0;
    wait_done(k);
    chk("rst_restart", {addrs[0], beats[HDR]}, 16'hB0B0);
    chk("seq_rst", seq_errs(8'h30), 0);

    // held start through DONE
    @(negedge clk_50mhz);
    kick(8'h90);
    wait_done(k);
    bad = 0;
    n0 = addrs.size();
    repeat (20) begin
      @(negedge clk_50mhz);
      if (!done || busy) bad++;
    end
    chk("hold_done", bad, 0);
    chk("hold_no_read", addrs.size() - n0, 0);
    start = 1'b0;
    @(negedge clk_50mhz);
    chk("hold_release", done, 1'b0);
    beats.delete();
    addrs.delete();
    start = 1'b1;
    @(negedge clk_50mhz);
    chk("fresh_busy", busy, 1'b1);
    start = 1'b0;
    wait_done(k);
    chk("seq_fresh", seq_errs(8'h90), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
